// File: rtl/dt_peak_scan.sv
// ============================================================================
// Module   : dt_peak_scan
// Purpose  : Raster scan of the distance map after DT completes. It reports the
//            peak distance, the address of the first peak and the object-pixel count.
//            Optional macro DT_PEAK_SUM_EN adds the sum_val_o output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module dt_peak_scan #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14,
    parameter int DW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    output logic             res_rd_o,
    output logic [AW-1:0]    res_addr_o,
    input  logic [DW-1:0]    res_di_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [DW-1:0]    max_val_o,
    output logic [AW-1:0]    max_addr_o,
    output logic [AW:0]      obj_cnt_o
`ifdef DT_PEAK_SUM_EN
    ,
    output logic [AW+DW-1:0] sum_val_o
`endif
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic          rd_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] tag_addr_q;
    logic          tag_vld_q;
    logic [DW-1:0] max_val_q;
    logic [AW-1:0] max_addr_q;
    logic [AW:0]   obj_cnt_q;
    logic          w_start_acc;

    // A start pulse arriving while busy (SCAN or DRAIN) is dropped.
    assign w_start_acc = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_start_acc) state_d = S_SCAN;
            S_SCAN:  if (addr_q == LAST_ADDR) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  if (w_start_acc) state_d = S_SCAN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state_q == S_SCAN) || (state_q == S_DRAIN);
        valid_o = (state_q == S_DONE);
    end

    // The tag follows the read by one cycle so each res_di_i is matched to its address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q       <= 1'b0;
            addr_q     <= '0;
            tag_addr_q <= '0;
            tag_vld_q  <= 1'b0;
            max_val_q  <= '0;
            max_addr_q <= '0;
            obj_cnt_q  <= '0;
        end else if (w_start_acc) begin
            rd_q       <= 1'b1;
            addr_q     <= '0;
            tag_addr_q <= '0;
            tag_vld_q  <= 1'b0;
            max_val_q  <= '0;
            max_addr_q <= '0;
            obj_cnt_q  <= '0;
        end else begin
            tag_addr_q <= addr_q;
            tag_vld_q  <= rd_q;
            if (state_q == S_SCAN) begin
                if (addr_q == LAST_ADDR) begin
                    rd_q <= 1'b0;
                end else begin
                    addr_q <= addr_q + AW'(1);
                end
            end
            if (tag_vld_q) begin
                if (res_di_i > max_val_q) begin
                    max_val_q  <= res_di_i;
                    max_addr_q <= tag_addr_q;
                end
                if (res_di_i != '0) begin
                    obj_cnt_q <= obj_cnt_q + (AW+1)'(1);
                end
            end
        end
    end

`ifdef DT_PEAK_SUM_EN
    logic [AW+DW-1:0] sum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
        end else if (w_start_acc) begin
            sum_q <= '0;
        end else if (tag_vld_q) begin
            sum_q <= sum_q + (AW+DW)'(res_di_i);
        end
    end

    assign sum_val_o = sum_q;
`endif

    assign res_rd_o   = rd_q;
    assign res_addr_o = addr_q;
    assign max_val_o  = max_val_q;
    assign max_addr_o = max_addr_q;
    assign obj_cnt_o  = obj_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dt_peak_scan.sv
// ============================================================================
// Module   : tb_dt_peak_scan
// Purpose  : Self-checking bench for dt_peak_scan with a synchronous res memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dt_peak_scan;

    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int AW     = 14;
    localparam int DW     = 8;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int LAT    = NPIX + 2;
    localparam int BUDGET = NPIX + 200;

    logic             clk     = 1'b0;
    logic             rst     = 1'b0;
    logic             start_i = 1'b0;
    logic             res_rd_o;
    logic [AW-1:0]    res_addr_o;
    logic [DW-1:0]    res_di  = '0;
    logic             busy_o;
    logic             valid_o;
    logic [DW-1:0]    max_val_o;
    logic [AW-1:0]    max_addr_o;
    logic [AW:0]      obj_cnt_o;
`ifdef DT_PEAK_SUM_EN
    logic [AW+DW-1:0] sum_val_o;
`endif

    logic [DW-1:0] mem [NPIX];

    int checks = 0;
    int errors = 0;
    int exp_max, exp_addr, exp_cnt, exp_sum;
    int obs_cyc, obs_reads, obs_addr_err, obs_busy_err;

    dt_peak_scan #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .res_rd_o   (res_rd_o),
        .res_addr_o (res_addr_o),
        .res_di_i   (res_di),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .max_val_o  (max_val_o),
        .max_addr_o (max_addr_o),
        .obj_cnt_o  (obj_cnt_o)
`ifdef DT_PEAK_SUM_EN
        ,
        .sum_val_o  (sum_val_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (res_rd_o) res_di <= mem[res_addr_o];
    end

    // Reference: whole-map statistics straight from the definition.
    task automatic ref_model();
        exp_max = 0; exp_addr = 0; exp_cnt = 0; exp_sum = 0;
        for (int i = 0; i < NPIX; i++) begin
            int v;
            v = int'(mem[i]);
            if (v > exp_max) begin exp_max = v; exp_addr = i; end
            if (v != 0) exp_cnt++;
            exp_sum += v;
        end
    endtask

    // Pulse start and run until valid; optionally re-pulse start at cycle extra_at.
    task automatic run_scan(input int extra_at);
        int rd_idx;
        rd_idx = 0; obs_addr_err = 0; obs_busy_err = 0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        obs_cyc = 1;
        while (!valid_o && obs_cyc < BUDGET) begin
            if (res_rd_o) begin
                if (int'(res_addr_o) != rd_idx) obs_addr_err++;
                rd_idx++;
            end
            if (!busy_o) obs_busy_err++;
            @(negedge clk);
            obs_cyc++;
            start_i = (obs_cyc == extra_at);
        end
        start_i = 1'b0;
        obs_reads = rd_idx;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({res_rd_o, res_addr_o, busy_o, valid_o, max_val_o, max_addr_o, obj_cnt_o} !== '0) begin
            errors++; $display("FAIL reset_outputs got rd=%0b addr=%0d busy=%0b valid=%0b max=%0d maddr=%0d cnt=%0d exp all 0",
                               res_rd_o, res_addr_o, busy_o, valid_o, max_val_o, max_addr_o, obj_cnt_o);
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({res_rd_o, busy_o, valid_o} !== 3'b000) begin
            errors++; $display("FAIL idle_hold got rd=%0b busy=%0b valid=%0b exp 000", res_rd_o, busy_o, valid_o);
        end
    endtask

    task automatic test_zero_map();
        for (int i = 0; i < NPIX; i++) mem[i] = '0;
        ref_model();
        run_scan(0);
        checks++; if (obs_cyc !== LAT) begin errors++; $display("FAIL zero_latency got %0d exp %0d", obs_cyc, LAT); end
        checks++; if (obs_reads !== NPIX) begin errors++; $display("FAIL zero_reads got %0d exp %0d", obs_reads, NPIX); end
        checks++; if (obs_addr_err !== 0) begin errors++; $display("FAIL zero_addr_seq got %0d bad exp 0", obs_addr_err); end
        checks++; if (obs_busy_err !== 0) begin errors++; $display("FAIL zero_busy got %0d low cycles exp 0", obs_busy_err); end
        checks++; if (max_val_o !== DW'(exp_max)) begin errors++; $display("FAIL zero_max got %0d exp %0d", max_val_o, exp_max); end
        checks++; if (max_addr_o !== AW'(exp_addr)) begin errors++; $display("FAIL zero_maddr got %0d exp %0d", max_addr_o, exp_addr); end
        checks++; if (obj_cnt_o !== (AW+1)'(exp_cnt)) begin errors++; $display("FAIL zero_cnt got %0d exp %0d", obj_cnt_o, exp_cnt); end
`ifdef DT_PEAK_SUM_EN
        checks++; if (sum_val_o !== (AW+DW)'(exp_sum)) begin errors++; $display("FAIL zero_sum got %0d exp %0d", sum_val_o, exp_sum); end
`endif
    endtask

    // Two peaks of 5 over random non-zero background; second start arrives mid-scan.
    task automatic test_ties_restart();
        for (int i = 0; i < NPIX; i++) mem[i] = DW'($urandom_range(1, 4));
        mem[100]  = 8'd5;
        mem[9000] = 8'd5;
        ref_model();
        run_scan(5000);
        checks++; if (obs_cyc !== LAT) begin errors++; $display("FAIL ties_latency got %0d exp %0d", obs_cyc, LAT); end
        checks++; if (obs_reads !== NPIX) begin errors++; $display("FAIL ties_reads got %0d exp %0d", obs_reads, NPIX); end
        checks++; if (obs_addr_err !== 0) begin errors++; $display("FAIL ties_addr_seq got %0d bad exp 0", obs_addr_err); end
        checks++; if (max_val_o !== DW'(exp_max)) begin errors++; $display("FAIL ties_max got %0d exp %0d", max_val_o, exp_max); end
        checks++; if (max_addr_o !== AW'(exp_addr)) begin errors++; $display("FAIL ties_maddr got %0d exp %0d", max_addr_o, exp_addr); end
        checks++; if (obj_cnt_o !== (AW+1)'(exp_cnt)) begin errors++; $display("FAIL ties_cnt got %0d exp %0d", obj_cnt_o, exp_cnt); end
`ifdef DT_PEAK_SUM_EN
        checks++; if (sum_val_o !== (AW+DW)'(exp_sum)) begin errors++; $display("FAIL ties_sum got %0d exp %0d", sum_val_o, exp_sum); end
`endif
    endtask

    // Peak on the final pixel (sampled in DRAIN); start pulse lands on DRAIN->DONE.
    task automatic test_last_pixel();
        for (int i = 0; i < NPIX; i++) mem[i] = 8'd1;
        mem[NPIX-1] = 8'd255;
        ref_model();
        run_scan(LAT - 1);
        checks++; if (obs_cyc !== LAT) begin errors++; $display("FAIL last_latency got %0d exp %0d", obs_cyc, LAT); end
        checks++; if (max_val_o !== DW'(exp_max)) begin errors++; $display("FAIL last_max got %0d exp %0d", max_val_o, exp_max); end
        checks++; if (max_addr_o !== AW'(exp_addr)) begin errors++; $display("FAIL last_maddr got %0d exp %0d", max_addr_o, exp_addr); end
        checks++; if (obj_cnt_o !== (AW+1)'(exp_cnt)) begin errors++; $display("FAIL last_cnt got %0d exp %0d", obj_cnt_o, exp_cnt); end
`ifdef DT_PEAK_SUM_EN
        checks++; if (sum_val_o !== (AW+DW)'(exp_sum)) begin errors++; $display("FAIL last_sum got %0d exp %0d", sum_val_o, exp_sum); end
`endif
        repeat (3) @(negedge clk);
        checks++;
        if ({valid_o, busy_o, res_rd_o} !== 3'b100) begin
            errors++; $display("FAIL last_hold got valid=%0b busy=%0b rd=%0b exp 100", valid_o, busy_o, res_rd_o);
        end
        checks++; if (max_addr_o !== AW'(exp_addr)) begin errors++; $display("FAIL last_hold_maddr got %0d exp %0d", max_addr_o, exp_addr); end
    endtask

    // Reset 3000 cycles into a scan, then a clean scan of the single-pixel map.
    task automatic test_midscan_reset();
        for (int i = 0; i < NPIX; i++) mem[i] = '0;
        mem[8256] = 8'd7;
        ref_model();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        repeat (2999) @(negedge clk);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %0b exp 1", busy_o); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({res_rd_o, res_addr_o, busy_o, valid_o, max_val_o, max_addr_o, obj_cnt_o} !== '0) begin
            errors++; $display("FAIL midrst_outputs got rd=%0b addr=%0d busy=%0b valid=%0b max=%0d maddr=%0d cnt=%0d exp all 0",
                               res_rd_o, res_addr_o, busy_o, valid_o, max_val_o, max_addr_o, obj_cnt_o);
        end
        @(negedge clk); rst = 1'b1;
        run_scan(0);
        checks++; if (obs_cyc !== LAT) begin errors++; $display("FAIL single_latency got %0d exp %0d", obs_cyc, LAT); end
        checks++; if (obs_addr_err !== 0) begin errors++; $display("FAIL single_addr_seq got %0d bad exp 0", obs_addr_err); end
        checks++; if (max_val_o !== DW'(exp_max)) begin errors++; $display("FAIL single_max got %0d exp %0d", max_val_o, exp_max); end
        checks++; if (max_addr_o !== AW'(exp_addr)) begin errors++; $display("FAIL single_maddr got %0d exp %0d", max_addr_o, exp_addr); end
        checks++; if (obj_cnt_o !== (AW+1)'(exp_cnt)) begin errors++; $display("FAIL single_cnt got %0d exp %0d", obj_cnt_o, exp_cnt); end
`ifdef DT_PEAK_SUM_EN
        checks++; if (sum_val_o !== (AW+DW)'(exp_sum)) begin errors++; $display("FAIL single_sum got %0d exp %0d", sum_val_o, exp_sum); end
`endif
    endtask

    initial begin
        test_reset();
        test_zero_map();
        test_ties_restart();
        test_last_pixel();
        test_midscan_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
